pump_cfg_ctrl: RTL and testbench

//  Button-driven configuration front-end for the pump timer: the command end of the pump timer interface.

---
 rtl/pump_cfg_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/pump_cfg_ctrl.sv | 137 +++++++++++++
 tb/tb_pump_cfg_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pump_cfg_pkg.sv
// Shared encodings for the pump configuration front-end: FSM states
// (which double as the edit_field codes shown on the LCD) and pump masks.
package pump_cfg_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_SEL    = 2'd1;
  localparam logic [1:0] ST_PERIOD = 2'd2;
  localparam logic [1:0] ST_ON     = 2'd3;

  localparam logic [1:0] PUMP_A  = 2'b01;
  localparam logic [1:0] PUMP_B  = 2'b10;
  localparam logic [1:0] PUMP_AB = 2'b11;

  // Rotates the pump mask 01->10->11->01 (up) or the reverse (down).
  function automatic logic [1:0] sel_step(input logic [1:0] sel, input logic up);
    logic [1:0] r;
    case (sel)
      PUMP_A:  r = up ? PUMP_B  : PUMP_AB;
      PUMP_B:  r = up ? PUMP_AB : PUMP_A;
      default: r = up ? PUMP_A  : PUMP_B;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stable-level counter and a
// one-cycle press pulse on each accepted 0->1 transition.
module btn_debounce #(
  parameter int CLOCK_FREQ  = 100_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam longint CNT_RAW = longint'(DEBOUNCE_MS) * longint'(CLOCK_FREQ) / 1000;
  localparam int     DB_CNT  = (CNT_RAW < 1) ? 1 : int'(CNT_RAW);
  localparam int     CNT_W   = $clog2(DB_CNT + 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // The counter runs only while the synchronised input disagrees with the
  // accepted level; any bounce back to the accepted level restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CNT - 1)) begin
        stable <= sync2;
        cnt    <= '0;
        press  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pump_cfg_ctrl.sv
// Button-driven pump timer configuration: edit FSM, shadow/committed values
// and timer arm sequencing. Optional macro: ON_TIME_CLAMP_EN.
module pump_cfg_ctrl
  import pump_cfg_pkg::*;
#(
  parameter int CLOCK_FREQ     = 100_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int DEFAULT_PERIOD = 60,
  parameter int DEFAULT_ON     = 5,
  parameter int PERIOD_STEP    = 10,
  parameter int MIN_PERIOD     = 2,
  parameter int MAX_PERIOD     = 3600,
  parameter int MAX_ON         = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_ok,
  input  logic        btn_force,
  output logic [1:0]  pump_select,
  output logic [31:0] period_seconds,
  output logic [31:0] pulse_on_time,
  output logic        timer_start,
  output logic        force_pulse,
  output logic [1:0]  edit_field,
  output logic        cfg_dirty
);

  localparam logic [31:0] P_DEF  = 32'(DEFAULT_PERIOD);
  localparam logic [31:0] O_DEF  = 32'(DEFAULT_ON);
  localparam logic [31:0] P_STEP = 32'(PERIOD_STEP);
  localparam logic [31:0] P_MIN  = 32'(MIN_PERIOD);
  localparam logic [31:0] P_MAX  = 32'(MAX_PERIOD);
  localparam logic [31:0] O_MAX  = 32'(MAX_ON);

  logic [4:0] btn_raw;
  logic [4:0] btn_ev;
  logic       ev_mode, ev_up, ev_down, ev_ok, ev_force;

  assign btn_raw = {btn_force, btn_ok, btn_down, btn_up, btn_mode};

  for (genvar g = 0; g < 5; g++) begin : g_btn
    btn_debounce #(
      .CLOCK_FREQ (CLOCK_FREQ),
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (btn_raw[g]),
      .press(btn_ev[g])
    );
  end

  assign {ev_force, ev_ok, ev_down, ev_up, ev_mode} = btn_ev;

  logic [1:0]  state;
  logic [1:0]  sh_sel;
  logic [31:0] sh_period;
  logic [31:0] sh_on;
  logic        rearm_pend;

  logic [31:0] per_inc, per_dec, on_inc, on_dec, on_commit;
  logic        edit_en;

  always_comb begin
    per_inc = (sh_period >= P_MAX - P_STEP) ? P_MAX : sh_period + P_STEP;
    per_dec = (sh_period <= P_MIN + P_STEP) ? P_MIN : sh_period - P_STEP;
    on_inc  = (sh_on >= O_MAX) ? O_MAX : sh_on + 32'd1;
    on_dec  = (sh_on <= 32'd1) ? 32'd1 : sh_on - 32'd1;
`ifdef ON_TIME_CLAMP_EN
    on_commit = (sh_on >= sh_period) ? sh_period - 32'd1 : sh_on;
`else
    on_commit = sh_on;
`endif
    // Simultaneous up+down cancel out; ok and mode take precedence over edits.
    edit_en = (ev_up ^ ev_down) && !ev_ok && !ev_mode && (state != ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_RUN;
      sh_sel         <= PUMP_A;
      sh_period      <= P_DEF;
      sh_on          <= O_DEF;
      pump_select    <= PUMP_A;
      period_seconds <= P_DEF;
      pulse_on_time  <= O_DEF;
      timer_start    <= 1'b0;
      rearm_pend     <= 1'b0;
      force_pulse    <= 1'b0;
    end else begin
      force_pulse <= ev_force;
      if (rearm_pend) begin
        timer_start <= 1'b1;
        rearm_pend  <= 1'b0;
      end
      if (ev_ok) begin
        if (state == ST_RUN) begin
          if (!rearm_pend) timer_start <= ~timer_start;
        end else begin
          // Commit lands with timer_start low; the re-rise follows next cycle,
          // so the timer always sees the new values when it restarts.
          pump_select    <= sh_sel;
          period_seconds <= sh_period;
          pulse_on_time  <= on_commit;
          sh_on          <= on_commit;
          state          <= ST_RUN;
          timer_start    <= 1'b0;
          rearm_pend     <= 1'b1;
        end
      end else if (ev_mode) begin
        if (state == ST_ON) begin
          state     <= ST_RUN;
          sh_sel    <= pump_select;
          sh_period <= period_seconds;
          sh_on     <= pulse_on_time;
        end else begin
          state <= state + 2'd1;
        end
      end else if (edit_en) begin
        case (state)
          ST_SEL:    sh_sel    <= sel_step(sh_sel, ev_up);
          ST_PERIOD: sh_period <= ev_up ? per_inc : per_dec;
          ST_ON:     sh_on     <= ev_up ? on_inc : on_dec;
          default:   ;
        endcase
      end
    end
  end

  assign edit_field = state;
  assign cfg_dirty  = (sh_sel != pump_select) || (sh_period != period_seconds) ||
                      (sh_on != pulse_on_time);

endmodule

// File: tb/tb_pump_cfg_ctrl.sv
// Self-checking bench for pump_cfg_ctrl with a 4-cycle debounce count.
module tb_pump_cfg_ctrl;

  localparam logic [4:0] B_M = 5'b00001;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_K = 5'b01000;
  localparam logic [4:0] B_F = 5'b10000;
`ifdef ON_TIME_CLAMP_EN
  localparam int ON_CL = 9;
`else
  localparam int ON_CL = 15;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_mode, btn_up, btn_down, btn_ok, btn_force;
  logic [1:0]  pump_select;
  logic [31:0] period_seconds;
  logic [31:0] pulse_on_time;
  logic        timer_start;
  logic        force_pulse;
  logic [1:0]  edit_field;
  logic        cfg_dirty;

  always #5 clk = ~clk;

  pump_cfg_ctrl #(
    .CLOCK_FREQ (1000),
    .DEBOUNCE_MS(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_mode      (btn_mode),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_ok        (btn_ok),
    .btn_force     (btn_force),
    .pump_select   (pump_select),
    .period_seconds(period_seconds),
    .pulse_on_time (pulse_on_time),
    .timer_start   (timer_start),
    .force_pulse   (force_pulse),
    .edit_field    (edit_field),
    .cfg_dirty     (cfg_dirty)
  );

  typedef struct {
    logic [4:0]  btn;
    int          rep;
    logic [69:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [69:0] exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;

  // {edit_field, pump_select, period, on_time, timer_start, cfg_dirty}
  function automatic logic [69:0] pack(input int f, s, p, o, t, d);
    return {2'(f), 2'(s), 32'(p), 32'(o), 1'(t), 1'(d)};
  endfunction

  function automatic logic [69:0] obs();
    return {edit_field, pump_select, period_seconds, pulse_on_time, timer_start, cfg_dirty};
  endfunction

  task automatic add(input logic [4:0] b, input int r, input int f, s, p, o, t, d);
    vec_t v;
    v.btn = b;
    v.rep = r;
    v.exp = pack(f, s, p, o, t, d);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [4:0] b);
    {btn_force, btn_ok, btn_down, btn_up, btn_mode} = b;
  endtask

  task automatic press(input logic [4:0] b);
    @(posedge clk); #1 set_btn(b);
    repeat (8) @(posedge clk);
    #1 set_btn(5'b0);
    repeat (8) @(posedge clk);
  endtask

  initial begin
    int fcnt, bad, c_p, c_lo, c_hi;

    add(5'b0,  1, 0, 1,   60,  5, 0, 0);
    add(B_M,   1, 1, 1,   60,  5, 0, 0);
    add(B_U,   1, 1, 1,   60,  5, 0, 1);
    add(B_M,   1, 2, 1,   60,  5, 0, 1);
    add(B_U,   2, 2, 1,   60,  5, 0, 1);
    add(B_M,   1, 3, 1,   60,  5, 0, 1);
    add(B_U,   1, 3, 1,   60,  5, 0, 1);
    add(B_K,   1, 0, 2,   80,  6, 1, 0);
    add(B_U,   1, 0, 2,   80,  6, 1, 0);
    add(B_D,   1, 0, 2,   80,  6, 1, 0);
    add(B_K,   1, 0, 2,   80,  6, 0, 0);
    add(B_K,   1, 0, 2,   80,  6, 1, 0);
    add(B_M,   1, 1, 2,   80,  6, 1, 0);
    add(B_U|B_D, 1, 1, 2, 80,  6, 1, 0);
    add(B_D,   1, 1, 2,   80,  6, 1, 1);
    add(B_M,   2, 3, 2,   80,  6, 1, 1);
    add(B_M,   1, 0, 2,   80,  6, 1, 0);
    add(B_M|B_K, 1, 0, 2, 80,  6, 0, 0);
    add(B_M,   1, 1, 2,   80,  6, 0, 0);
    add(B_K,   1, 0, 2,   80,  6, 1, 0);
    add(B_M,   2, 2, 2,   80,  6, 1, 0);
    add(B_D,   7, 2, 2,   80,  6, 1, 1);
    add(B_M,   1, 3, 2,   80,  6, 1, 1);
    add(B_U,   9, 3, 2,   80,  6, 1, 1);
    add(B_K,   1, 0, 2,   10, ON_CL, 1, 0);
    add(B_M,   3, 3, 2,   10, ON_CL, 1, 0);
    add(B_D,  20, 3, 2,   10, ON_CL, 1, 1);
    add(B_K,   1, 0, 2,   10,  1, 1, 0);
    add(B_M,   3, 3, 2,   10,  1, 1, 0);
    add(B_D,   1, 3, 2,   10,  1, 1, 0);
    add(B_M,   1, 0, 2,   10,  1, 1, 0);
    add(B_M,   2, 2, 2,   10,  1, 1, 0);
    add(B_D,   2, 2, 2,   10,  1, 1, 1);
    add(B_K,   1, 0, 2,    2,  1, 1, 0);
    add(B_M,   2, 2, 2,    2,  1, 1, 0);
    add(B_D,   1, 2, 2,    2,  1, 1, 0);
    add(B_U, 400, 2, 2,    2,  1, 1, 1);
    add(B_K,   1, 0, 2, 3600,  1, 1, 0);
    add(B_M,   2, 2, 2, 3600,  1, 1, 0);
    add(B_U,   1, 2, 2, 3600,  1, 1, 0);
    add(B_M,   2, 0, 2, 3600,  1, 1, 0);

    rst_n = 1'b0;
    set_btn(5'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", obs(), pack(0, 1, 60, 5, 0, 0));
    chk_int("reset_force", int'(force_pulse), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp);
      for (int r = 0; r < vecs[i].rep; r++) press(vecs[i].btn);
      @(negedge clk);
      chk($sformatf("vec%0d", i), obs(), exp_q.pop_front());
    end

    // force in SEL: single-cycle pulse, nothing else moves
    press(B_M);
    @(posedge clk); #1 btn_force = 1'b1;
    fcnt = 0;
    bad = 0;
    repeat (14) begin
      @(negedge clk);
      if (force_pulse) fcnt++;
      if (edit_field !== 2'd1 || timer_start !== 1'b1) bad++;
    end
    btn_force = 1'b0;
    repeat (10) @(posedge clk);
    chk_int("force_len", fcnt, 1);
    chk_int("force_side_effects", bad, 0);

    // commit while armed: timer_start 1,0,1 and new period before re-rise
    press(B_M);
    press(B_D);
    @(posedge clk); #1 btn_ok = 1'b1;
    c_p = -1;
    c_lo = -1;
    c_hi = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (c_p < 0 && period_seconds == 32'd3590) c_p = i;
      if (c_lo < 0 && timer_start == 1'b0) c_lo = i;
      else if (c_lo >= 0 && c_hi < 0 && timer_start == 1'b1) c_hi = i;
    end
    btn_ok = 1'b0;
    repeat (10) @(posedge clk);
    chk_int("rearm_low_cycles", c_hi - c_lo, 1);
    chk_int("rearm_value_before_rise", int'(c_p >= 0 && c_p < c_hi), 1);
    @(negedge clk);
    chk("rearm_final", obs(), pack(0, 2, 3590, 1, 1, 0));

    // bouncing up in PERIOD counts once; committed value waits for ok
    press(B_M);
    press(B_M);
    press(B_D);
    press(B_D);
    @(posedge clk); #1 btn_up = 1'b1;
    @(posedge clk); #1 btn_up = 1'b0;
    @(posedge clk); #1 btn_up = 1'b1;
    repeat (10) @(posedge clk);
    #1 btn_up = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bounce_before_ok", obs(), pack(2, 2, 3590, 1, 1, 1));
    press(B_K);
    @(negedge clk);
    chk("bounce_commit", obs(), pack(0, 2, 3580, 1, 1, 0));

    // reset mid-edit with a press still in the debouncer
    press(B_M);
    press(B_U);
    @(posedge clk); #1 btn_mode = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_async", obs(), pack(0, 1, 60, 5, 0, 0));
    repeat (2) @(posedge clk);
    #1 btn_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("reset_mid_edit", obs(), pack(0, 1, 60, 5, 0, 0));
    chk_int("reset_mid_edit_force", int'(force_pulse), 0);
    chk_int("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
